// File: rtl/writeback_queue_pkg.sv
// Shared defaults and types for the writeback queue and its bypass matcher.
package writeback_queue_pkg;
  localparam int unsigned WBQ_DATA_WIDTH    = 32;
  localparam int unsigned WBQ_NUM_REGISTERS = 32;
  localparam int unsigned WBQ_AW            = $clog2(WBQ_NUM_REGISTERS);
  localparam logic [WBQ_AW-1:0] WBQ_REG_ZERO = '0;

  typedef struct packed {
    logic [WBQ_AW-1:0]         addr;
    logic [WBQ_DATA_WIDTH-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/writeback_queue_match.sv
// Priority matcher: finds the newest occupied queue entry whose address equals ra.
// Register zero never matches.
module writeback_queue_match
  import writeback_queue_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] entry_addr,
  input  logic [DEPTH-1:0][DW-1:0] entry_data,
  input  logic [DEPTH-1:0]         valid_mask,
  input  logic [PW-1:0]            head,
  input  logic [AW-1:0]            ra,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  logic [PW-1:0] idx_s;

  // Walk oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head + PW'(i);
      if (valid_mask[idx_s] && (entry_addr[idx_s] == ra) && (ra != AW'(WBQ_REG_ZERO))) begin
        hit  = 1'b1;
        data = entry_data[idx_s];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback queue with per-read-port bypass lookup.
// Bypass matchers are built only when WRITEBACK_QUEUE_BYPASS_EN is defined.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DATA_WIDTH    = WBQ_DATA_WIDTH,
  parameter int NUM_REGISTERS = WBQ_NUM_REGISTERS,
  parameter int DEPTH         = 4,
  localparam int AW           = $clog2(NUM_REGISTERS),
  localparam int PW           = $clog2(DEPTH)
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_VALID,
  output logic                  o_READY,
  input  logic [AW-1:0]         i_WA,
  input  logic [DATA_WIDTH-1:0] i_D,
  input  logic                  i_STALL,
  output logic                  o_WE,
  output logic [AW-1:0]         o_WA,
  output logic [DATA_WIDTH-1:0] o_D,
  input  logic [AW-1:0]         i_RA0,
  input  logic [AW-1:0]         i_RA1,
  output logic                  o_HIT0,
  output logic                  o_HIT1,
  output logic [DATA_WIDTH-1:0] o_BD0,
  output logic [DATA_WIDTH-1:0] o_BD1,
  output logic [PW:0]           o_COUNT
);

  logic [DEPTH-1:0][AW-1:0]         addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
  logic [PW:0]                      count_q, count_d;
  logic                             ready_s, push_s, pop_s, nonempty_s;
  logic [DEPTH-1:0]                 valid_mask_s;
  logic [PW-1:0]                    off_s;

  // Handshake, drain and next-state; zero-address results are acknowledged but dropped.
  always_comb begin
    nonempty_s = (count_q != '0);
    ready_s    = (count_q != (PW+1)'(DEPTH));
    pop_s      = nonempty_s && !i_STALL && i_RST;
    push_s     = i_VALID && ready_s && (i_WA != AW'(WBQ_REG_ZERO));
    addr_d     = addr_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (push_s) begin
      addr_d[tail_q] = i_WA;
      data_d[tail_q] = i_D;
      tail_d         = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    count_d = count_q + (PW+1)'(push_s) - (PW+1)'(pop_s);
  end

  // Occupancy mask: slot j is live when its distance from head is below count.
  always_comb begin
    valid_mask_s = '0;
    off_s        = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off_s           = PW'(j) - head_q;
      valid_mask_s[j] = ({1'b0, off_s} < count_q);
    end
  end

  // Pointer and occupancy state with synchronous active-low reset.
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge i_CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign o_READY = ready_s;
  assign o_COUNT = count_q;
  assign o_WE    = pop_s;
  assign o_WA    = nonempty_s ? addr_q[head_q] : '0;
  assign o_D     = nonempty_s ? data_q[head_q] : '0;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  writeback_queue_match #(.DW(DATA_WIDTH), .AW(AW), .DEPTH(DEPTH)) u_match0 (
    .entry_addr(addr_q), .entry_data(data_q), .valid_mask(valid_mask_s),
    .head(head_q), .ra(i_RA0), .hit(o_HIT0), .data(o_BD0)
  );
  writeback_queue_match #(.DW(DATA_WIDTH), .AW(AW), .DEPTH(DEPTH)) u_match1 (
    .entry_addr(addr_q), .entry_data(data_q), .valid_mask(valid_mask_s),
    .head(head_q), .ra(i_RA1), .hit(o_HIT1), .data(o_BD1)
  );
`else
  logic unused_s;
  assign unused_s = ^{valid_mask_s, i_RA0, i_RA1};
  assign o_HIT0   = 1'b0;
  assign o_HIT1   = 1'b0;
  assign o_BD0    = '0;
  assign o_BD1    = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, valid, stall, ready, we, hit0, hit1;
  logic [4:0] wa, ra0, ra1, owa;
  logic [31:0] d, od, bd0, bd1;
  logic [2:0] count;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  writeback_queue #(.DATA_WIDTH(32), .NUM_REGISTERS(32), .DEPTH(DEPTH)) dut (
    .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .o_READY(ready), .i_WA(wa), .i_D(d),
    .i_STALL(stall), .o_WE(we), .o_WA(owa), .o_D(od), .i_RA0(ra0), .i_RA1(ra1),
    .o_HIT0(hit0), .o_HIT1(hit1), .o_BD0(bd0), .o_BD1(bd1), .o_COUNT(count)
  );

  // Reference model: a plain FIFO of pending writes.
  wbq_entry_t mq[$];

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
    end else begin
      bit acc;
      acc = valid && (mq.size() < DEPTH);
      if (mq.size() != 0 && !stall) void'(mq.pop_front());
      if (acc && wa != 5'd0) mq.push_back('{addr: wa, data: d});
    end
  end

  function automatic logic [32:0] m_byp(input logic [4:0] ra);
    logic [32:0] r;
    r = 33'd0;
    if (BYP && ra != 5'd0)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].addr == ra) r = {1'b1, mq[i].data};
    return r;
  endfunction

  function automatic logic [107:0] m_vec();
    logic we_e;
    logic [4:0] wa_e;
    logic [31:0] d_e;
    we_e = rst && mq.size() != 0 && !stall;
    wa_e = (mq.size() != 0) ? mq[0].addr : 5'd0;
    d_e  = (mq.size() != 0) ? mq[0].data : 32'd0;
    return {mq.size() < DEPTH, 3'(mq.size()), we_e, wa_e, d_e, m_byp(ra0), m_byp(ra1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] dd, input logic s);
    valid = v; wa = a; d = dd; stall = s;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    rst = 1'b1; #1;
    vectors++;
    if ({ready, count, we, owa, od, hit0, hit1, bd0, bd1} !== {1'b1, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b cnt=%0d we=%b wa=%0d d=%h h=%b%b", ready, count, we, owa, od, hit0, hit1);
    end
  endtask

  task automatic test_basic();
    ra0 = 5'd5; ra1 = 5'd0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    vectors++;
    if ({ready, hit0} !== {1'b1, 1'b0}) begin
      miscompares++; $display("FAIL basic_offer: got rdy=%b hit0=%b expected 1 0", ready, hit0);
    end
    tick(); drive(1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if ({we, owa, od} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL basic_write: got we=%b wa=%0d d=%h expected 1 5 deadbeef", we, owa, od);
    end
    vectors++;
    if ({hit0, bd0} !== {BYP, BYP ? 32'hDEADBEEF : 32'h0}) begin
      miscompares++; $display("FAIL basic_bypass: got hit=%b bd=%h", hit0, bd0);
    end
    tick();
    vectors++;
    if ({we, count} !== {1'b0, 3'd0}) begin
      miscompares++; $display("FAIL basic_idle: got we=%b cnt=%0d expected 0 0", we, count);
    end
  endtask

  task automatic test_stall_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(i * 17), 1'b1);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    vectors++;
    if ({count, ready, we} !== {3'd4, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL stall_full: got cnt=%0d rdy=%b we=%b expected 4 0 0", count, ready, we);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      vectors++;
      if ({we, owa, od} !== {1'b1, 5'(i), 32'(i * 17)}) begin
        miscompares++; $display("FAIL stall_drain%0d: got we=%b wa=%0d d=%h", i, we, owa, od);
      end
      tick();
    end
  endtask

  task automatic test_bypass_dup();
    drive(1'b1, 5'd7, 32'hA, 1'b1); tick();
    drive(1'b1, 5'd7, 32'hB, 1'b1); tick();
    ra0 = 5'd7; ra1 = 5'd3;
    drive(1'b1, 5'd3, 32'hC, 1'b1);
    vectors++;
    if ({hit0, bd0, hit1, bd1} !== {BYP, BYP ? 32'hB : 32'h0, 1'b0, 32'h0}) begin
      miscompares++; $display("FAIL bypass_dup: got h0=%b bd0=%h h1=%b bd1=%h", hit0, bd0, hit1, bd1);
    end
    tick(); drive(1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if ({hit1, bd1} !== {BYP, BYP ? 32'hC : 32'h0}) begin
      miscompares++; $display("FAIL bypass_next: got h1=%b bd1=%h", hit1, bd1);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({we, owa, od} !== {1'b1, (i == 2) ? 5'd3 : 5'd7, (i == 0) ? 32'hA : ((i == 1) ? 32'hB : 32'hC)}) begin
        miscompares++; $display("FAIL dup_order%0d: got we=%b wa=%0d d=%h", i, we, owa, od);
      end
      tick();
    end
  endtask

  task automatic test_zero_addr();
    ra0 = 5'd0;
    drive(1'b1, 5'd0, 32'h1234, 1'b0);
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++; $display("FAIL zero_ready: got %b expected 1", ready);
    end
    tick(); drive(1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if ({count, we, hit0} !== {3'd0, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL zero_drop: got cnt=%0d we=%b hit0=%b expected 0 0 0", count, we, hit0);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 5'd10, 32'h100, 1'b1); tick();
    drive(1'b1, 5'd11, 32'h101, 1'b1); tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 5'(12 + k), 32'(258 + k), 1'b0);
      vectors++;
      if ({count, we, owa, od} !== {3'd2, 1'b1, 5'(10 + k), 32'(256 + k)}) begin
        miscompares++; $display("FAIL wrap%0d: got cnt=%0d we=%b wa=%0d d=%h", k, count, we, owa, od);
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick(); tick();
    vectors++;
    if (count !== 3'd0) begin
      miscompares++; $display("FAIL wrap_empty: got cnt=%0d expected 0", count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 32'(i + 1), 1'b1); tick();
    end
    rst = 1'b0; drive(1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if (we !== 1'b0) begin
      miscompares++; $display("FAIL reset_cycle_we: got %b expected 0", we);
    end
    tick(); rst = 1'b1; ra0 = 5'd20; ra1 = 5'd22; #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({count, we, hit0, hit1} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL reset_mid%0d: got cnt=%0d we=%b h=%b%b", i, count, we, hit0, hit1);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [107:0] exp_v;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      drive(1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
      ra0 = 5'($urandom_range(0, 7)); ra1 = 5'($urandom_range(0, 7)); #1;
      exp_v = m_vec();
      vectors++;
      if ({ready, count, we, owa, od, hit0, bd0, hit1, bd1} !== exp_v) begin
        miscompares++;
        $display("FAIL random%0d: got %h expected %h", n, {ready, count, we, owa, od, hit0, bd0, hit1, bd1}, exp_v);
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; stall = 1'b0; wa = 5'd0; d = 32'd0; ra0 = 5'd0; ra1 = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall_fill();
    test_bypass_dup();
    test_zero_addr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
